// File: rtl/hilo_capture_unit.sv
// ============================================================================
// hilo_capture_unit: HI/LO holding registers behind the shift-add multiplier.
// Optional macro HILO_BYPASS_EN forwards mul_product to reads in the capture cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hilo_capture_unit #(
  parameter int MUL_LATENCY = 34,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mul_start,
  input  logic [63:0] mul_product,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        rd_en,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      hi, hi_nxt;
  logic [31:0]      lo, lo_nxt;
  logic             cap_cycle;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      IDLE: begin
        if (mul_start) begin
          cnt_nxt   = CNT_LOAD;
          state_nxt = WAIT;
        end else begin
          if (mthi) hi_nxt = wdata;
          if (mtlo) lo_nxt = wdata;
        end
      end
      WAIT: begin
        // A restart abandons the in-flight product, even on the capture edge.
        if (mul_start) begin
          cnt_nxt = CNT_LOAD;
        end else if (cnt == '0) begin
          hi_nxt    = mul_product[63:32];
          lo_nxt    = mul_product[31:0];
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state == WAIT);
  assign cap_cycle = busy && (cnt == '0);

`ifdef HILO_BYPASS_EN
  assign stall   = busy & ((rd_en & ~cap_cycle) | mthi | mtlo);
  assign rd_data = cap_cycle ? (rd_sel ? mul_product[63:32] : mul_product[31:0])
                             : (rd_sel ? hi : lo);
`else
  logic unused_cap;
  assign unused_cap = cap_cycle;
  assign stall      = busy & (rd_en | mthi | mtlo);
  assign rd_data    = rd_sel ? hi : lo;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hilo_capture_unit.sv
// Bench for hilo_capture_unit: edge-indexed behavioural model checked every
// cycle, plus directed scenarios with literal expectations.
`default_nettype none

module tb_hilo_capture_unit;

  localparam int LAT = 34;
`ifdef HILO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mul_start = 1'b0;
  logic [63:0] mul_product = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        rd_en = 1'b0;
  logic        rd_sel = 1'b0;
  logic [31:0] rd_data;
  logic        busy;
  logic        stall;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  hilo_capture_unit #(.MUL_LATENCY(LAT), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .mul_start(mul_start), .mul_product(mul_product),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_data(rd_data), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  // Model: a pending multiply lands on absolute edge m_cap.
  int          edge_no = 0;
  int          m_cap = 0;
  bit          m_pend = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always @(posedge clk) begin
    edge_no <= edge_no + 1;
    if (reset) begin
      m_hi <= '0; m_lo <= '0; m_pend <= 1'b0;
    end else if (mul_start) begin
      m_pend <= 1'b1; m_cap <= edge_no + LAT;
    end else if (m_pend) begin
      if (edge_no == m_cap) begin
        m_hi <= mul_product[63:32]; m_lo <= mul_product[31:0]; m_pend <= 1'b0;
      end
    end else begin
      if (mthi) m_hi <= wdata;
      if (mtlo) m_lo <= wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      bit          win;
      logic [31:0] exp_rd;
      bit          exp_stall;
      win       = m_pend && (edge_no == m_cap);
      exp_stall = m_pend && ((rd_en && !(BYP && win)) || mthi || mtlo);
      if (BYP && win) exp_rd = rd_sel ? mul_product[63:32] : mul_product[31:0];
      else            exp_rd = rd_sel ? m_hi : m_lo;
      chk("model_busy",  {31'b0, busy},  {31'b0, m_pend});
      chk("model_stall", {31'b0, stall}, {31'b0, exp_stall});
      chk("model_rd",    rd_data, exp_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset
    tick();
    reset = 1'b0;
    check_en = 1'b1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_rd_lo", rd_data, 32'd0);
    rd_sel = 1'b1; #1;
    chk("rst_rd_hi", rd_data, 32'd0);

    // 2/3. basic capture with a read held throughout
    rd_en = 1'b1; mul_start = 1'b1;
    tick();                                   // edge 0
    mul_start = 1'b0;
    for (int k = 1; k <= LAT; k++) begin      // now just after edge k-1
      if (k == 30) mul_product = 64'h0000_0002_FFFF_FFFE;
      chk("cap_busy", {31'b0, busy}, 32'd1);
      if (BYP && k == LAT) begin
        chk("byp_stall", {31'b0, stall}, 32'd0);
        chk("byp_rd", rd_data, 32'h2);
      end else begin
        chk("rd_stall", {31'b0, stall}, 32'd1);
      end
      tick();
    end
    chk("cap_busy_done", {31'b0, busy}, 32'd0);
    chk("cap_stall_done", {31'b0, stall}, 32'd0);
    chk("cap_hi", rd_data, 32'h2);
    chk("model_hi_pin", m_hi, 32'h2);
    rd_sel = 1'b0; #1;
    chk("cap_lo", rd_data, 32'hFFFF_FFFE);
    rd_en = 1'b0;

    // 4. writes in IDLE, then during WAIT
    mthi = 1'b1; wdata = 32'hDEAD_BEEF; #1;
    chk("wr_idle_stall", {31'b0, stall}, 32'd0);
    tick();
    mthi = 1'b0; rd_sel = 1'b1; #1;
    chk("wr_idle_hi", rd_data, 32'hDEAD_BEEF);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234_5678;
    tick();
    mthi = 1'b0; mtlo = 1'b0; #1;
    chk("wr_both_hi", rd_data, 32'h1234_5678);
    rd_sel = 1'b0; #1;
    chk("wr_both_lo", rd_data, 32'h1234_5678);

    mul_product = 64'h1111_2222_3333_4444;
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0; mthi = 1'b1; wdata = 32'hCAFE_F00D; rd_sel = 1'b1; #1;
    chk("wr_wait_stall", {31'b0, stall}, 32'd1);
    chk("wr_wait_hi", rd_data, 32'h1234_5678);
    begin
      int n = 0;
      while (busy && n < 40) begin tick(); n++; end
      chk("wr_wait_timeout", {31'b0, busy}, 32'd0);
    end
    chk("wr_after_cap_hi", rd_data, 32'h1111_2222);
    tick();
    mthi = 1'b0; #1;
    chk("wr_held_hi", rd_data, 32'hCAFE_F00D);
    rd_sel = 1'b0; #1;
    chk("wr_held_lo", rd_data, 32'h3333_4444);

    // 5. restart at edge 10 moves capture to edge 44
    mul_product = 64'hBAD0_BAD0_BAD0_BAD0;
    mul_start = 1'b1;
    tick();                                   // edge 0
    mul_start = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    mul_start = 1'b1;
    tick();                                   // edge 10
    mul_start = 1'b0;
    for (int k = 11; k <= 44; k++) begin      // now just after edge k-1
      chk("rs_busy", {31'b0, busy}, 32'd1);
      if (k == 40) mul_product = 64'h5555_6666_7777_8888;
      tick();
    end
    chk("rs_busy_done", {31'b0, busy}, 32'd0);
    chk("rs_lo", rd_data, 32'h7777_8888);
    rd_sel = 1'b1; #1;
    chk("rs_hi", rd_data, 32'h5555_6666);

    // 6. reset mid-WAIT abandons the capture
    mul_product = 64'hFFFF_FFFF_FFFF_FFFF;
    mul_start = 1'b1;
    tick();                                   // edge 0
    mul_start = 1'b0;
    for (int k = 1; k <= 19; k++) tick();
    reset = 1'b1;
    tick();                                   // edge 20
    reset = 1'b0; #1;
    chk("mr_busy", {31'b0, busy}, 32'd0);
    chk("mr_hi", rd_data, 32'd0);
    for (int k = 21; k <= 36; k++) tick();
    chk("mr_no_cap_busy", {31'b0, busy}, 32'd0);
    chk("mr_no_cap_hi", rd_data, 32'd0);
    rd_sel = 1'b0; #1;
    chk("mr_no_cap_lo", rd_data, 32'd0);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
